rs_encoder_param: RTL and testbench

RS_ENCODER_PARAM -- requirements
Module: rs_encoder_param

---
 rtl/rs_encoder_param.sv | 212 +++++++++++++++++++++
 tb/tb_rs_encoder_param.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : rs_encoder_param
//  Brief    : Systematic Reed-Solomon encoder over GF(16) (x^4+x+1) with an
//             LFSR parity generator; ENC_QUEUE_EN adds a one-entry request slot.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_encoder_param #(
    parameter int NSYM = 15,
    parameter int KSYM = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                encodeMessage,
    input  logic [4*KSYM-1:0]   message,
    output logic [4*NSYM-1:0]   codeWordVector,
    output logic                encoderBusy,
    output logic                codeWordValid,
    output logic                requestDropped,
    output logic                queueFull
);

    localparam int         c_PAR      = NSYM - KSYM;
    localparam logic [3:0] c_LAST_SYM = 4'(KSYM - 1);

    generate
        if (NSYM < 3 || NSYM > 15 || KSYM < 1 || c_PAR < 2 || c_PAR > 14 || (c_PAR % 2) != 0) begin : g_badParams
            $error("rs_encoder_param: illegal NSYM/KSYM combination");
        end
    endgenerate

    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] prod;
        logic [3:0] term;
        prod = 4'd0;
        term = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) prod = prod ^ term;
            term = {term[2:0], 1'b0} ^ (term[3] ? 4'b0011 : 4'b0000);
        end
        return prod;
    endfunction

    // Monic g(x) = prod (x + alpha^i), i = 1..c_PAR; coefficient j lives in bits [4j+3:4j]
    function automatic logic [59:0] genPoly();
        logic [59:0] gv;
        logic [3:0]  root;
        logic [3:0]  lower;
        gv       = 60'd0;
        gv[3:0]  = 4'd1;
        root     = 4'd1;
        for (int i = 1; i <= c_PAR && i <= 14; i++) begin
            root = gfMul(root, 4'b0010);
            for (int j = 14; j >= 0; j--) begin
                if (j > 0) lower = gv[4*(j-1) +: 4];
                else       lower = 4'd0;
                gv[4*j +: 4] = lower ^ gfMul(root, gv[4*j +: 4]);
            end
        end
        return gv;
    endfunction

    localparam logic [59:0] c_GEN_POLY = genPoly();

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [4*KSYM-1:0]     r_msg;
    logic [4*KSYM-1:0]     w_startMsg;
    logic [4*c_PAR-1:0]    r_lfsr;
    logic [4*c_PAR-1:0]    w_lfsrNext;
    logic [3:0]            r_count;
    logic [3:0]            w_curSym;
    logic [3:0]            w_feedback;
    logic [4*NSYM-1:0]     r_codeWord;
    logic                  r_valid;
    logic                  r_dropped;
    logic                  w_start;
    logic                  w_load;
    logic                  w_drop;
`ifdef ENC_QUEUE_EN
    logic                  r_pendValid;
    logic [4*KSYM-1:0]     r_pendMsg;
    logic                  w_pendSet;
    logic                  w_pendClr;
`endif

    always_comb begin
        w_curSym = 4'd0;
        for (int j = 0; j < KSYM; j++) begin
            if (r_count == 4'(j)) w_curSym = r_msg[4*j +: 4];
        end
    end

    assign w_feedback = w_curSym ^ r_lfsr[4*c_PAR-1 -: 4];

    generate
        for (genvar i = 0; i < c_PAR; i++) begin : g_lfsrTap
            if (i == 0) begin : g_first
                assign w_lfsrNext[3:0] = gfMul(w_feedback, c_GEN_POLY[3:0]);
            end else begin : g_rest
                assign w_lfsrNext[4*i +: 4] = r_lfsr[4*(i-1) +: 4] ^ gfMul(w_feedback, c_GEN_POLY[4*i +: 4]);
            end
        end
    endgenerate

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_startMsg  = message;
`ifdef ENC_QUEUE_EN
        w_pendSet   = 1'b0;
        w_pendClr   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (encodeMessage) begin
                    w_start     = 1'b1;
                    w_nextState = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == 4'd0) w_nextState = S_DONE;
`ifdef ENC_QUEUE_EN
                if (encodeMessage) begin
                    if (r_pendValid) w_drop    = 1'b1;
                    else             w_pendSet = 1'b1;
                end
`else
                w_drop = encodeMessage;
`endif
            end
            S_DONE: begin
                w_load      = 1'b1;
                w_nextState = S_IDLE;
`ifdef ENC_QUEUE_EN
                // A request arriving with the slot empty starts right away, so no idle gap
                if (r_pendValid) begin
                    w_start     = 1'b1;
                    w_startMsg  = r_pendMsg;
                    w_nextState = S_SHIFT;
                    w_pendClr   = 1'b1;
                    w_pendSet   = encodeMessage;
                end else if (encodeMessage) begin
                    w_start     = 1'b1;
                    w_nextState = S_SHIFT;
                end
`else
                w_drop = encodeMessage;
`endif
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_msg      <= '0;
            r_lfsr     <= '0;
            r_count    <= 4'd0;
            r_codeWord <= '0;
            r_valid    <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_valid   <= w_load;
            r_dropped <= w_drop;
            if (w_load) r_codeWord <= {r_msg, r_lfsr};
            if (w_start) begin
                r_msg   <= w_startMsg;
                r_lfsr  <= '0;
                r_count <= c_LAST_SYM;
            end else if (r_state == S_SHIFT) begin
                r_lfsr  <= w_lfsrNext;
                r_count <= r_count - 4'd1;
            end
        end
    end

`ifdef ENC_QUEUE_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pendValid <= 1'b0;
            r_pendMsg   <= '0;
        end else if (w_pendSet) begin
            r_pendValid <= 1'b1;
            r_pendMsg   <= message;
        end else if (w_pendClr) begin
            r_pendValid <= 1'b0;
        end
    end

    assign queueFull = r_pendValid;
`else
    assign queueFull = 1'b0;
`endif

    assign codeWordVector = r_codeWord;
    assign encoderBusy    = (r_state != S_IDLE);
    assign codeWordValid  = r_valid;
    assign requestDropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_encoder_param
//  Brief    : Self-checking bench for rs_encoder_param (15/9, 15/13, 7/3) against
//             a log-table long-division reference; honours ENC_QUEUE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rs_encoder_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [2:0]  enc;
    logic [51:0] msgBus;
    logic [59:0] cw9;
    logic [59:0] cw13;
    logic [27:0] cw7;
    logic [2:0]  busy;
    logic [2:0]  valid;
    logic [2:0]  dropped;
    logic [2:0]  qfull;

    int checks   = 0;
    int failures = 0;

    logic [3:0] expT [0:14];
    int         logT [0:15];

    rs_encoder_param #(.NSYM(15), .KSYM(9)) dut9 (
        .clk(clk), .reset_n(reset_n), .encodeMessage(enc[0]), .message(msgBus[35:0]),
        .codeWordVector(cw9), .encoderBusy(busy[0]), .codeWordValid(valid[0]),
        .requestDropped(dropped[0]), .queueFull(qfull[0]));

    rs_encoder_param #(.NSYM(15), .KSYM(13)) dut13 (
        .clk(clk), .reset_n(reset_n), .encodeMessage(enc[1]), .message(msgBus[51:0]),
        .codeWordVector(cw13), .encoderBusy(busy[1]), .codeWordValid(valid[1]),
        .requestDropped(dropped[1]), .queueFull(qfull[1]));

    rs_encoder_param #(.NSYM(7), .KSYM(3)) dut7 (
        .clk(clk), .reset_n(reset_n), .encodeMessage(enc[2]), .message(msgBus[11:0]),
        .codeWordVector(cw7), .encoderBusy(busy[2]), .codeWordValid(valid[2]),
        .requestDropped(dropped[2]), .queueFull(qfull[2]));

    function automatic logic [3:0] mulRef(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return expT[(logT[a] + logT[b]) % 15];
    endfunction

    // Codeword by polynomial long division of m(x)*x^2T by the expanded generator
    function automatic logic [59:0] refEncode(input int n, input int k, input logic [51:0] m);
        logic [3:0]  g [0:15];
        logic [3:0]  r [0:15];
        logic [3:0]  lead;
        logic [3:0]  lower;
        logic [59:0] res;
        int          t;
        t = n - k;
        for (int i = 0; i < 16; i++) begin
            g[i] = 4'd0;
            r[i] = 4'd0;
        end
        g[0] = 4'd1;
        for (int i = 1; i <= t; i++) begin
            for (int j = t; j >= 0; j--) begin
                if (j > 0) lower = g[j-1];
                else       lower = 4'd0;
                g[j] = lower ^ mulRef(g[j], expT[i]);
            end
        end
        for (int j = 0; j < k; j++) r[j+t] = m[4*j +: 4];
        for (int d = n - 1; d >= t; d--) begin
            lead = r[d];
            for (int i = 0; i <= t; i++) r[d-t+i] = r[d-t+i] ^ mulRef(lead, g[i]);
        end
        res = 60'd0;
        for (int i = 0; i < t; i++) res[4*i +: 4] = r[i];
        for (int j = 0; j < k; j++) res[4*(j+t) +: 4] = m[4*j +: 4];
        return res;
    endfunction

    function automatic logic [3:0] evalAt(input logic [59:0] c, input int n, input logic [3:0] x);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = n - 1; i >= 0; i--) acc = mulRef(acc, x) ^ c[4*i +: 4];
        return acc;
    endfunction

    function automatic int kOf(input int s);
        return (s == 1) ? 13 : ((s == 2) ? 3 : 9);
    endfunction

    function automatic int nOf(input int s);
        return (s == 2) ? 7 : 15;
    endfunction

    function automatic logic [59:0] cwOf(input int s);
        case (s)
            1:       return cw13;
            2:       return {32'd0, cw7};
            default: return cw9;
        endcase
    endfunction

    function automatic logic [51:0] randMsg(input int k);
        logic [63:0] r;
        logic [51:0] mask;
        r    = {$urandom, $urandom};
        mask = (52'd1 << (4 * k)) - 52'd1;
        return r[51:0] & mask;
    endfunction

    // Launches one job; returns at the negedge where codeWordValid is seen (lat = -1 on timeout)
    task automatic runJob(input int s, input logic [51:0] m, output logic [59:0] cw,
                          output int lat, output int busyCnt);
        @(negedge clk);
        msgBus = m;
        enc[s] = 1'b1;
        @(negedge clk);
        enc[s]  = 1'b0;
        lat     = -1;
        busyCnt = 0;
        cw      = 60'd0;
        for (int n = 1; n <= 40; n++) begin
            if (busy[s]) busyCnt++;
            if (valid[s]) begin
                lat = n;
                cw  = cwOf(s);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enc     = 3'b000;
        msgBus  = 52'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, dropped, qfull} !== 12'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0", {busy, valid, dropped, qfull});
        end
        checks++;
        if (cw9 !== 60'd0 || cw13 !== 60'd0 || cw7 !== 28'd0) begin
            failures++;
            $display("FAIL reset_codeword: got %h %h %h required 0", cw9, cw13, cw7);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_known_vectors();
        logic [59:0] cw;
        logic [59:0] expCw;
        int          lat;
        int          bc;
        runJob(0, 52'h87, cw, lat, bc);
        checks++;
        if (lat !== 11) begin failures++; $display("FAIL known_latency: got %0d required 11", lat); end
        checks++;
        if (bc !== 10) begin failures++; $display("FAIL known_busy_cycles: got %0d required 10", bc); end
        checks++;
        if (cw[59:24] !== 36'h87) begin failures++; $display("FAIL known_systematic: got %h required %h", cw[59:24], 36'h87); end
        expCw = refEncode(15, 9, 52'h87);
        checks++;
        if (cw !== expCw) begin failures++; $display("FAIL known_codeword: got %h required %h", cw, expCw); end
        for (int j = 1; j <= 6; j++) begin
            checks++;
            if (evalAt(cw, 15, expT[j]) !== 4'd0)
                begin failures++; $display("FAIL syndrome_%0d: got %h required 0", j, evalAt(cw, 15, expT[j])); end
        end
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b0) begin failures++; $display("FAIL valid_pulse_width: got %b required 0", valid[0]); end
        checks++;
        if (cw9 !== cw) begin failures++; $display("FAIL codeword_hold: got %h required %h", cw9, cw); end
        runJob(1, 52'h1, cw, lat, bc);
        checks++;
        if (cw !== 60'h000000000000168) begin failures++; $display("FAIL k13_unit: got %h required 000000000000168", cw); end
        checks++;
        if (lat !== 15) begin failures++; $display("FAIL k13_latency: got %0d required 15", lat); end
    endtask

    task automatic test_linearity();
        logic [59:0] cwA;
        logic [59:0] cwB;
        logic [59:0] cwC;
        int          lat;
        int          bc;
        runJob(0, 52'h87, cwA, lat, bc);
        runJob(0, 52'hE0, cwB, lat, bc);
        runJob(0, 52'h87 ^ 52'hE0, cwC, lat, bc);
        checks++;
        if (cwB !== refEncode(15, 9, 52'hE0)) begin failures++; $display("FAIL lin_b: got %h required %h", cwB, refEncode(15, 9, 52'hE0)); end
        checks++;
        if (cwC !== (cwA ^ cwB)) begin failures++; $display("FAIL lin_sum: got %h required %h", cwC, cwA ^ cwB); end
    endtask

    task automatic test_random();
        logic [51:0] m;
        logic [59:0] cw;
        logic [59:0] expCw;
        int          lat;
        int          bc;
        for (int s = 0; s < 3; s++) begin
            for (int it = 0; it < 8; it++) begin
                m = (it == 0) ? 52'd0 : randMsg(kOf(s));
                runJob(s, m, cw, lat, bc);
                expCw = refEncode(nOf(s), kOf(s), m);
                checks++;
                if (cw !== expCw) begin failures++; $display("FAIL rand_cw_s%0d_%0d: got %h required %h", s, it, cw, expCw); end
                checks++;
                if (lat !== kOf(s) + 2) begin failures++; $display("FAIL rand_lat_s%0d_%0d: got %0d required %0d", s, it, lat, kOf(s) + 2); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [51:0] a;
        logic [51:0] b;
        int          gotAt;
        int          pulses;
        a = randMsg(9);
        b = randMsg(9) | 52'h1;
        gotAt  = -1;
        pulses = 0;
        @(negedge clk);
        msgBus = a;
        enc[0] = 1'b1;
        @(negedge clk);
        enc[0] = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL b2b_done_busy: got %b required 1", busy[0]); end
        msgBus = b;
        enc[0] = 1'b1;
        @(negedge clk);
        enc[0] = 1'b0;
        checks++;
        if (valid[0] !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b required 1", valid[0]); end
        checks++;
        if (cw9 !== refEncode(15, 9, a)) begin failures++; $display("FAIL b2b_first_cw: got %h required %h", cw9, refEncode(15, 9, a)); end
`ifdef ENC_QUEUE_EN
        checks++;
        if (busy[0] !== 1'b1 || dropped[0] !== 1'b0)
            begin failures++; $display("FAIL b2b_restart: got busy=%b drop=%b required busy=1 drop=0", busy[0], dropped[0]); end
        for (int n = 12; n <= 40; n++) begin
            @(negedge clk);
            if (valid[0]) begin gotAt = n; break; end
        end
        checks++;
        if (gotAt !== 21) begin failures++; $display("FAIL b2b_second_at: got %0d required 21", gotAt); end
        checks++;
        if (cw9 !== refEncode(15, 9, b)) begin failures++; $display("FAIL b2b_second_cw: got %h required %h", cw9, refEncode(15, 9, b)); end
`else
        checks++;
        if (dropped[0] !== 1'b1 || busy[0] !== 1'b0)
            begin failures++; $display("FAIL b2b_drop: got drop=%b busy=%b required drop=1 busy=0", dropped[0], busy[0]); end
        repeat (20) begin
            @(negedge clk);
            if (valid[0]) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL b2b_extra_pulses: got %0d required 0", pulses); end
`endif
    endtask

    task automatic test_queue();
        logic [51:0] a;
        logic [51:0] m1;
        logic        qExp;
        logic        dExp;
        int          gotAt;
        a     = randMsg(9);
        m1    = randMsg(9);
        gotAt = -1;
`ifdef ENC_QUEUE_EN
        qExp = 1'b1;
        dExp = 1'b0;
`else
        qExp = 1'b0;
        dExp = 1'b1;
`endif
        @(negedge clk);
        msgBus = a;
        enc[0] = 1'b1;
        @(negedge clk);
        enc[0] = 1'b0;
        @(negedge clk);
        msgBus = m1;
        enc[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (qfull[0] !== qExp || dropped[0] !== dExp)
            begin failures++; $display("FAIL queue_first: got full=%b drop=%b required full=%b drop=%b", qfull[0], dropped[0], qExp, dExp); end
        msgBus = randMsg(9);
        @(negedge clk);
        checks++;
        if (dropped[0] !== 1'b1) begin failures++; $display("FAIL queue_second_drop: got %b required 1", dropped[0]); end
        msgBus = randMsg(9);
        @(negedge clk);
        enc[0] = 1'b0;
        checks++;
        if (dropped[0] !== 1'b1) begin failures++; $display("FAIL queue_third_drop: got %b required 1", dropped[0]); end
        repeat (6) @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || cw9 !== refEncode(15, 9, a))
            begin failures++; $display("FAIL queue_first_cw: got v=%b %h required v=1 %h", valid[0], cw9, refEncode(15, 9, a)); end
        checks++;
        if (qfull[0] !== 1'b0) begin failures++; $display("FAIL queue_slot_release: got %b required 0", qfull[0]); end
`ifdef ENC_QUEUE_EN
        for (int n = 12; n <= 40; n++) begin
            @(negedge clk);
            if (valid[0]) begin gotAt = n; break; end
        end
        checks++;
        if (gotAt !== 21 || cw9 !== refEncode(15, 9, m1))
            begin failures++; $display("FAIL queue_pending_job: got at=%0d %h required at=21 %h", gotAt, cw9, refEncode(15, 9, m1)); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [59:0] cw;
        logic [51:0] c;
        int          pulses;
        int          lat;
        int          bc;
        pulses = 0;
        @(negedge clk);
        msgBus = randMsg(9);
        enc[0] = 1'b1;
        @(negedge clk);
        enc[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        enc[0]  = 1'b1;
        msgBus  = randMsg(9);
        @(negedge clk);
        checks++;
        if ({busy[0], valid[0], dropped[0], qfull[0]} !== 4'd0)
            begin failures++; $display("FAIL midreset_flags: got %b required 0000", {busy[0], valid[0], dropped[0], qfull[0]}); end
        checks++;
        if (cw9 !== 60'd0) begin failures++; $display("FAIL midreset_cw: got %h required 0", cw9); end
        reset_n = 1'b1;
        enc[0]  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (valid[0] || busy[0]) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL midreset_aborted: got %0d active cycles required 0", pulses); end
        c = randMsg(9);
        runJob(0, c, cw, lat, bc);
        checks++;
        if (cw !== refEncode(15, 9, c) || lat !== 11)
            begin failures++; $display("FAIL midreset_recover: got %h lat=%0d required %h lat=11", cw, lat, refEncode(15, 9, c)); end
    endtask

    initial begin
        expT[0] = 4'd1;
        for (int i = 1; i < 15; i++)
            expT[i] = {expT[i-1][2:0], 1'b0} ^ (expT[i-1][3] ? 4'h3 : 4'h0);
        logT[0] = 0;
        for (int i = 0; i < 15; i++) logT[expT[i]] = i;

        test_reset();
        test_known_vectors();
        test_linearity();
        test_random();
        test_back_to_back();
        test_queue();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
